// File: rtl/load_align_unit_pkg.sv
// Shared definitions for the load alignment path: op codes, access sizes,
// FSM states and exception codes.
package load_align_unit_pkg;

    // op[1:0] matches the store byte-enable size encoding; op[2] selects zero extension
    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10
    } load_size_e;

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LB  = 3'b010;
    localparam logic [2:0] OP_LWU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;
    localparam logic [2:0] OP_LBU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    localparam logic [4:0] EXC_NONE = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_DBE  = 5'h07;

    // True when the request must be refused without touching memory.
    function automatic logic load_addr_err(input logic [2:0] op, input logic [1:0] addr_lo);
        logic err;
        case (op)
            OP_LW, OP_LWU: err = (addr_lo != 2'b00);
            OP_LH, OP_LHU: err = addr_lo[0];
            OP_LB, OP_LBU: err = 1'b0;
            default:       err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/load_align_unit_extend.sv
// Combinational lane select and sign/zero extension of a read word.
module load_extend
    import load_align_unit_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  op_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sext;

    always_comb begin
        case (addr_lo_i)
            2'b00:   byte_sel = word_i[7:0];
            2'b01:   byte_sel = word_i[15:8];
            2'b10:   byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
        sext     = ~op_i[2];

        case (op_i[1:0])
            SZ_WORD: data_o = word_i;
            SZ_HALF: data_o = {{16{sext & half_sel[15]}}, half_sel};
            SZ_BYTE: data_o = {{24{sext & byte_sel[7]}}, byte_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/load_align_unit.sv
// Load path of the M stage: alignment check, single word-aligned read with a
// watchdog, and an extended result returned over a valid/ready handshake.
module load_align_unit
    import load_align_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic [2:0]  req_op_i,
    output logic        rd_en_o,
    output logic [31:0] rd_addr_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_data_o,
    output logic        exc_adel_o,
    output logic        exc_bus_o,
    output logic        busy_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [2:0]        op_q, op_d;
    logic [31:0]       data_q, data_d;
    logic [4:0]        exc_q, exc_d;
    logic [31:0]       ext_data;

    load_extend u_extend (
        .word_i    (mem_rdata_i),
        .addr_lo_i (addr_q[1:0]),
        .op_i      (op_q),
        .data_o    (ext_data)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            op_q    <= '0;
            data_q  <= '0;
            exc_q   <= EXC_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            data_q  <= data_d;
            exc_q   <= exc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        op_d    = op_q;
        data_d  = data_q;
        exc_d   = exc_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    addr_d = req_addr_i;
                    op_d   = req_op_i;
                    cnt_d  = '0;
                    if (load_addr_err(req_op_i, req_addr_i[1:0])) begin
                        exc_d   = EXC_ADEL;
                        data_d  = '0;
                        state_d = ST_RESP;
                    end else begin
                        exc_d   = EXC_NONE;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (mem_rvalid_i) begin
                    data_d  = ext_data;
                    exc_d   = EXC_NONE;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    data_d  = '0;
                    exc_d   = EXC_DBE;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                // data is left as-is; only the flags are cleared on hand-off
                if (resp_ready_i) begin
                    exc_d   = EXC_NONE;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign req_ready_o  = (state_q == ST_IDLE);
    assign rd_en_o      = (state_q == ST_WAIT) && (cnt_q == '0);
    assign rd_addr_o    = {addr_q[31:2], 2'b00};
    assign resp_valid_o = (state_q == ST_RESP);
    assign resp_data_o  = data_q;
    assign exc_adel_o   = (exc_q == EXC_ADEL);
    assign exc_bus_o    = (exc_q == EXC_DBE);
    assign busy_o       = (state_q == ST_WAIT) || (state_q == ST_RESP);

endmodule

// File: tb/tb_load_align_unit.sv
// Self-checking bench for load_align_unit: vector table plus hand-written
// sequences for stall, timeout and reset corners, checked through a scoreboard.
module tb_load_align_unit;
    import load_align_unit_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic [2:0]  req_op_i;
    logic        rd_en_o;
    logic [31:0] rd_addr_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] resp_data_o;
    logic        exc_adel_o;
    logic        exc_bus_o;
    logic        busy_o;

    always #5 clk_i = ~clk_i;

    load_align_unit #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_addr_i   (req_addr_i),
        .req_op_i     (req_op_i),
        .rd_en_o      (rd_en_o),
        .rd_addr_o    (rd_addr_o),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_data_o  (resp_data_o),
        .exc_adel_o   (exc_adel_o),
        .exc_bus_o    (exc_bus_o),
        .busy_o       (busy_o)
    );

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  op;
        logic [31:0] rdata;
        int          lat;
        logic [31:0] exp_data;
        logic        exp_adel;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        adel;
        logic        bus;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[14];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_resp(input string name);
        exp_t e;
        check({name, " resp_valid"}, 32'(resp_valid_o), 32'd1);
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s scoreboard: got response expected none queued", name);
        end else begin
            e = sb_q.pop_front();
            check({name, " data"}, resp_data_o, e.data);
            check({name, " exc_adel"}, 32'(exc_adel_o), 32'(e.adel));
            check({name, " exc_bus"}, 32'(exc_bus_o), 32'(e.bus));
        end
    endtask

    task automatic release_resp(input string name);
        resp_ready_i = 1'b1;
        tick();
        resp_ready_i = 1'b0;
        check({name, " post resp_valid"}, 32'(resp_valid_o), 32'd0);
        check({name, " post exc"}, {30'd0, exc_adel_o, exc_bus_o}, 32'd0);
        check({name, " post req_ready"}, 32'(req_ready_o), 32'd1);
        check({name, " post busy"}, 32'(busy_o), 32'd0);
    endtask

    task automatic issue(input string name, input logic [31:0] addr, input logic [2:0] op);
        check({name, " req_ready"}, 32'(req_ready_o), 32'd1);
        req_valid_i = 1'b1;
        req_addr_i  = addr;
        req_op_i    = op;
        tick();
        req_valid_i = 1'b0;
    endtask

    task automatic run_vec(input string name, input vec_t v);
        exp_t e;
        e.data = v.exp_adel ? 32'd0 : v.exp_data;
        e.adel = v.exp_adel;
        e.bus  = 1'b0;
        sb_q.push_back(e);
        issue(name, v.addr, v.op);
        if (v.exp_adel) begin
            check({name, " rd_en"}, 32'(rd_en_o), 32'd0);
            check_resp(name);
        end else begin
            check({name, " rd_en"}, 32'(rd_en_o), 32'd1);
            check({name, " rd_addr"}, rd_addr_o, {v.addr[31:2], 2'b00});
            for (int i = 0; i < v.lat; i++) begin
                tick();
                check({name, " wait rd_en"}, 32'(rd_en_o), 32'd0);
                check({name, " wait busy"}, 32'(busy_o), 32'd1);
                check({name, " wait resp_valid"}, 32'(resp_valid_o), 32'd0);
            end
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = v.rdata;
            tick();
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = $urandom;
            check({name, " resp busy"}, 32'(busy_o), 32'd1);
            check_resp(name);
        end
        check({name, " resp rd_en"}, 32'(rd_en_o), 32'd0);
        release_resp(name);
    endtask

    function automatic vec_t mk(input logic [31:0] addr, input logic [2:0] op,
                                input logic [31:0] rdata, input int lat,
                                input logic [31:0] exp_data, input logic exp_adel);
        vec_t v;
        v.addr = addr; v.op = op; v.rdata = rdata; v.lat = lat;
        v.exp_data = exp_data; v.exp_adel = exp_adel;
        return v;
    endfunction

    initial begin
        exp_t e;

        vecs[0]  = mk(32'h0000_0003, OP_LB,  32'h80AB_CDEF, 0, 32'hFFFF_FF80, 1'b0);
        vecs[1]  = mk(32'h0000_0012, OP_LHU, 32'h9234_5678, 3, 32'h0000_9234, 1'b0);
        vecs[2]  = mk(32'h0000_0006, OP_LW,  32'h0,         0, 32'h0,         1'b1);
        vecs[3]  = mk(32'h0000_0008, 3'b011, 32'h0,         0, 32'h0,         1'b1);
        vecs[4]  = mk(32'h0000_0100, OP_LW,  32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 1'b0);
        vecs[5]  = mk(32'h0000_0002, OP_LBU, 32'h12F4_5678, 0, 32'h0000_00F4, 1'b0);
        vecs[6]  = mk(32'h0000_0002, OP_LB,  32'h12F4_5678, 2, 32'hFFFF_FFF4, 1'b0);
        vecs[7]  = mk(32'h0000_0000, OP_LH,  32'h1234_8765, 0, 32'hFFFF_8765, 1'b0);
        vecs[8]  = mk(32'h0000_0001, OP_LH,  32'h0,         0, 32'h0,         1'b1);
        vecs[9]  = mk(32'hABCD_0004, OP_LWU, 32'hCAFE_F00D, 2, 32'hCAFE_F00D, 1'b0);
        vecs[10] = mk(32'h0000_0000, 3'b111, 32'h0,         0, 32'h0,         1'b1);
        vecs[11] = mk(32'h0000_0003, OP_LHU, 32'h0,         0, 32'h0,         1'b1);
        vecs[12] = mk(32'h0000_0001, OP_LBU, 32'h12F4_5678, 1, 32'h0000_0056, 1'b0);
        vecs[13] = mk(32'h0000_0022, OP_LWU, 32'h0,         0, 32'h0,         1'b1);

        rst_n_i      = 1'b0;
        req_valid_i  = 1'b0;
        req_addr_i   = '0;
        req_op_i     = '0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        resp_ready_i = 1'b0;
        tick();
        tick();
        check("reset resp_valid", 32'(resp_valid_o), 32'd0);
        check("reset resp_data", resp_data_o, 32'd0);
        check("reset flags", {29'd0, exc_adel_o, exc_bus_o, rd_en_o}, 32'd0);
        check("reset busy", 32'(busy_o), 32'd0);
        check("reset rd_addr", rd_addr_o, 32'd0);
        check("reset req_ready", 32'(req_ready_o), 32'd1);
        rst_n_i = 1'b1;
        tick();

        for (int i = 0; i < 14; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Stall in RESP with a request already waiting behind it
        e.data = 32'h0000_0056; e.adel = 1'b0; e.bus = 1'b0;
        sb_q.push_back(e);
        issue("stall", 32'h0000_0001, OP_LBU);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h12F4_5678;
        tick();
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;
        req_valid_i  = 1'b1;
        req_addr_i   = 32'h0000_0200;
        req_op_i     = OP_LW;
        for (int i = 0; i < 5; i++) begin
            check("stall resp_valid", 32'(resp_valid_o), 32'd1);
            check("stall data", resp_data_o, 32'h0000_0056);
            check("stall req_ready", 32'(req_ready_o), 32'd0);
            tick();
        end
        check_resp("stall");
        resp_ready_i = 1'b1;
        tick();
        resp_ready_i = 1'b0;
        check("stall idle resp_valid", 32'(resp_valid_o), 32'd0);
        check("stall idle req_ready", 32'(req_ready_o), 32'd1);
        tick();
        req_valid_i = 1'b0;
        check("queued busy", 32'(busy_o), 32'd1);
        check("queued rd_en", 32'(rd_en_o), 32'd1);
        check("queued rd_addr", rd_addr_o, 32'h0000_0200);
        e.data = 32'h1122_3344; e.adel = 1'b0; e.bus = 1'b0;
        sb_q.push_back(e);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h1122_3344;
        tick();
        mem_rvalid_i = 1'b0;
        check_resp("queued");
        release_resp("queued");

        // Watchdog: no rvalid, then a late rvalid that must be ignored
        e.data = 32'h0; e.adel = 1'b0; e.bus = 1'b1;
        sb_q.push_back(e);
        issue("timeout", 32'h0000_0040, OP_LW);
        check("timeout rd_en", 32'(rd_en_o), 32'd1);
        for (int i = 1; i < 16; i++) begin
            tick();
            check($sformatf("timeout wait%0d resp_valid", i), 32'(resp_valid_o), 32'd0);
            check($sformatf("timeout wait%0d rd_en", i), 32'(rd_en_o), 32'd0);
        end
        tick();
        check_resp("timeout");
        tick();
        tick();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hFFFF_FFFF;
        tick();
        mem_rvalid_i = 1'b0;
        check("late rvalid data", resp_data_o, 32'd0);
        check("late rvalid exc_bus", 32'(exc_bus_o), 32'd1);
        check("late rvalid exc_adel", 32'(exc_adel_o), 32'd0);
        check("late rvalid resp_valid", 32'(resp_valid_o), 32'd1);
        release_resp("timeout");

        // Reset in the middle of WAIT abandons the read
        issue("rstwait", 32'h0000_0080, OP_LW);
        tick();
        rst_n_i = 1'b0;
        #1;
        check("rstwait outputs", {27'd0, rd_en_o, resp_valid_o, exc_adel_o, exc_bus_o, busy_o}, 32'd0);
        check("rstwait resp_data", resp_data_o, 32'd0);
        check("rstwait rd_addr", rd_addr_o, 32'd0);
        tick();
        rst_n_i = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h5555_AAAA;
        tick();
        mem_rvalid_i = 1'b0;
        check("rstwait rvalid ignored", 32'(resp_valid_o), 32'd0);
        check("rstwait busy", 32'(busy_o), 32'd0);
        check("rstwait req_ready", 32'(req_ready_o), 32'd1);
        run_vec("post_reset LH", mk(32'h0000_0002, OP_LH, 32'h8001_0000, 0, 32'hFFFF_8001, 1'b0));

        check("scoreboard drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
- Read-side counterpart of the store byte-enable path in the M stage.
- Accepts a load request (address plus load type), checks alignment, and issues one word-aligned read to DM or the device bridge.
- Waits a variable number of cycles for read data, with a watchdog on the wait.
- Returns the selected byte or halfword, sign- or zero-extended, to the pipeline through a valid/ready handshake.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles in WAIT before a bus error is flagged; must be ≥2.
- CNT_W, 5: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- req_valid  in  1  load request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_addr  in  32  byte address of the load.
- req_op  in  3  load type: 000 LW, 001 LH, 010 LB, 101 LHU, 110 LBU, 100 treated as LW; 011 and 111 illegal.
- rd_en  out  1  one-cycle read strobe to memory.
- rd_addr  out  32  {addr[31:2],2'b00} of the latched request; held stable through WAIT.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read word; byte lane n = bits 8n+7:8n.
- resp_valid  out  1  result available.
- resp_ready  in  1  pipeline consumes result.
- resp_data  out  32  extended load result.
- exc_adel  out  1  address-error-on-load; valid with resp_valid.
- exc_bus  out  1  watchdog timeout; valid with resp_valid.
- busy  out  1  high in WAIT or RESP; drives the pipeline stall.

Behaviour:
- FSM states:
  - IDLE: req_ready=1. When req_valid=1, latch req_addr and req_op.
    - If the request is misaligned (LH/LHU with addr[0]=1, LW with addr[1:0]≠00) or the op is illegal: go to RESP with exc_adel=1 and resp_data=0. No memory access.
    - Otherwise go to WAIT with cnt=0.
  - WAIT: rd_en=1 only while cnt=0, so exactly one strobe per request. mem_rvalid is sampled in every WAIT cycle, including the cnt=0 cycle.
    - On rvalid: register the extended data and go to RESP.
    - Otherwise cnt+1. When cnt=TIMEOUT_CYCLES-1 and there is no rvalid: go to RESP with exc_bus=1 and resp_data=0.
  - RESP: resp_valid=1; resp_data and the exception flags are held stable.
    - When resp_ready=1: go to IDLE; resp_valid, exc_adel and exc_bus drop to 0 on the next edge.
    - No request is accepted in the same cycle.
- Extraction, from the latched addr[1:0]:
  - Byte: lane = addr[1:0].
  - Half: addr[1]=0 gives bits [15:0]; addr[1]=1 gives bits [31:16].
  - Sign extension when op[2]=0, zero extension when op[2]=1.
  - Word: passed through unchanged.
- Latency: accept at edge k, rd_en during cycle k+1. Zero-wait memory gives resp_valid from edge k+2. A misaligned request gives resp_valid from edge k+1.
- mem_rvalid is ignored outside WAIT, including a late rvalid after a timeout.
- Reset (async, any state): state=IDLE, cnt=0, rd_en=0, resp_valid=0, resp_data=0, exc_adel=0, exc_bus=0, busy=0, rd_addr=0. An in-flight read is abandoned.
- exc_adel and exc_bus are never both 1.

Decomposition:
- Shared package holds:
  - load op codes, with op[1:0] encoded identically to the store byte-enable op (00 word, 01 half, 10 byte) and op[2] as the unsigned flag;
  - FSM state encoding (IDLE, WAIT, RESP);
  - ExcCode constants for AdEL.
- Sub-module load_extend: combinational lane select and sign/zero extend, with inputs word, addr_lo[1:0], op[2:0] and output data[31:0]. It is instantiated once, between mem_rdata and the result register.

Test Plan:
- LB addr=0x0000_0003, op=010, rdata=0x80AB_CDEF returned on the rd_en cycle: resp_data=0xFFFF_FF80 at edge k+2; exactly one rd_en, rd_addr=0x0000_0000.
- LHU addr=0x0000_0012, op=101, rdata=0x9234_5678 returned 3 cycles after rd_en: resp_data=0x0000_9234; busy=1 throughout WAIT and RESP.
- LW addr=0x0000_0006: resp_valid at edge k+1 with exc_adel=1 and resp_data=0; rd_en never asserted. Repeat with op=011 at an aligned address: same response.
- No rvalid with TIMEOUT_CYCLES=16: exc_bus=1 exactly 16 cycles after entering WAIT. A spurious rvalid 2 cycles later leaves the held response unchanged.
- resp_ready held 0 for 5 cycles in RESP: resp_data stable and req_ready=0 throughout. After resp_ready=1, IDLE follows, and a queued req_valid is accepted one cycle later.
- reset asserted mid-WAIT, then rvalid arrives after release: all outputs 0, state IDLE, rvalid ignored, and the next LH addr=0x2 with rdata=0x8001_0000 gives 0xFFFF_8001.
